// File: rtl/imem_loadable.sv
// Loadable instruction memory for the 16-bit MIPS-style core.
// A program image is streamed in through a valid/ready load port. The fetch
// port has a registered, stall-aware read path with 1-cycle latency. A fetch
// at or beyond the end of the loaded image returns NOP_WORD and raises
// fetch_err.
module imem_loadable #(
  parameter int              IW       = 16,
  parameter int              AW       = 8,
  parameter int              DEPTH    = 256,
  parameter logic [IW-1:0]   NOP_WORD = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_busy,
  output logic [AW:0]   loaded_cnt,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_pc,
  input  logic          stall,
  output logic          fetch_valid,
  output logic [IW-1:0] instruction,
  output logic          fetch_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Index width sized to the array. Counts are AW+1 bits wide so that
  // DEPTH == 2**AW is still representable.
  localparam int          IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);

  logic [IW-1:0] mem [0:DEPTH-1];

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [AW:0]   wptr_r;
  logic [AW:0]   wptr_inc_s;
  logic [AW:0]   loaded_cnt_r;
  logic          load_ready_r;
  logic          load_busy_r;
  logic          fetch_valid_r;
  logic [IW-1:0] instruction_r;
  logic          fetch_err_r;
  logic          xfer_s;
  logic          final_s;
  logic          fetch_hit_s;
  logic          fetch_blocked_s;
  logic [IW-1:0] rd_data_s;

  // A same-cycle load_start discards the transfer (the load restarts).
  assign xfer_s          = load_ready_r & load_valid & ~load_start;
  assign wptr_inc_s      = wptr_r + ONE_CNT;
  assign final_s         = xfer_s & (load_last | (wptr_inc_s == DEPTH_CNT));
  assign fetch_hit_s     = ({1'b0, fetch_pc} < loaded_cnt_r);
  assign fetch_blocked_s = load_start | (state_r == ST_LOAD);
  assign rd_data_s       = mem[fetch_pc[IDXW-1:0]];

  assign load_ready  = load_ready_r;
  assign load_busy   = load_busy_r;
  assign loaded_cnt  = loaded_cnt_r;
  assign fetch_valid = fetch_valid_r;
  assign instruction = instruction_r;
  assign fetch_err   = fetch_err_r;

  // Next-state selection for the IDLE / LOAD / RUN controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) state_nxt_s = ST_LOAD;
        else            state_nxt_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (load_start)   state_nxt_s = ST_LOAD;
        else if (final_s) state_nxt_s = ST_RUN;
        else              state_nxt_s = ST_LOAD;
      end
      ST_RUN: begin
        if (load_start) state_nxt_s = ST_LOAD;
        else            state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Controller state, load handshake outputs, write pointer and image size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      load_ready_r <= 1'b0;
      load_busy_r  <= 1'b0;
      wptr_r       <= '0;
      loaded_cnt_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      load_ready_r <= (state_nxt_s == ST_LOAD);
      load_busy_r  <= (state_nxt_s == ST_LOAD);
      if (load_start) begin
        wptr_r       <= '0;
        loaded_cnt_r <= '0;
      end else if (xfer_s) begin
        wptr_r       <= wptr_inc_s;
        loaded_cnt_r <= wptr_inc_s;
      end else begin
        wptr_r       <= wptr_r;
        loaded_cnt_r <= loaded_cnt_r;
      end
    end
  end

  // Instruction storage write port. The array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem[wptr_r[IDXW-1:0]] <= load_data;
    end
  end

  // Registered fetch path: 1-cycle latency, held while stall is high, and
  // flushed whenever a load begins or is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_r <= 1'b0;
      instruction_r <= NOP_WORD;
      fetch_err_r   <= 1'b0;
    end else if (fetch_blocked_s) begin
      fetch_valid_r <= 1'b0;
      instruction_r <= instruction_r;
      fetch_err_r   <= 1'b0;
    end else if (!stall) begin
      fetch_valid_r <= fetch_req;
      if (fetch_req && fetch_hit_s) begin
        instruction_r <= rd_data_s;
        fetch_err_r   <= 1'b0;
      end else if (fetch_req) begin
        instruction_r <= NOP_WORD;
        fetch_err_r   <= 1'b1;
      end else begin
        instruction_r <= instruction_r;
        fetch_err_r   <= 1'b0;
      end
    end else begin
      fetch_valid_r <= fetch_valid_r;
      instruction_r <= instruction_r;
      fetch_err_r   <= fetch_err_r;
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: a default-size instance plus a
// DEPTH=4 / AW=2 instance that exercises load auto-termination at full depth.
module tb_imem_loadable;

  localparam int IW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          load_start, load_valid, load_last;
  logic [IW-1:0] load_data;
  logic          load_ready, load_busy;
  logic [AW:0]   loaded_cnt;
  logic          fetch_req, stall;
  logic [AW-1:0] fetch_pc;
  logic          fetch_valid, fetch_err;
  logic [IW-1:0] instruction;

  logic          d4_load_start, d4_load_valid, d4_load_last;
  logic [IW-1:0] d4_load_data;
  logic          d4_load_ready, d4_load_busy;
  logic [2:0]    d4_loaded_cnt;
  logic          d4_fetch_req, d4_stall;
  logic [1:0]    d4_fetch_pc;
  logic          d4_fetch_valid, d4_fetch_err;
  logic [IW-1:0] d4_instruction;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          err;
  } exp_t;

  exp_t          sb_q[$];
  exp_t          last_exp;
  logic          last_valid;
  logic [IW-1:0] model_mem [0:255];
  int            model_cnt;

  always #5 clk = ~clk;

  imem_loadable #(.IW(IW), .AW(AW), .DEPTH(256), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
    .loaded_cnt(loaded_cnt), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .stall(stall), .fetch_valid(fetch_valid), .instruction(instruction),
    .fetch_err(fetch_err)
  );

  imem_loadable #(.IW(IW), .AW(2), .DEPTH(4), .NOP_WORD(16'h0000)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_start(d4_load_start), .load_valid(d4_load_valid), .load_data(d4_load_data),
    .load_last(d4_load_last), .load_ready(d4_load_ready), .load_busy(d4_load_busy),
    .loaded_cnt(d4_loaded_cnt), .fetch_req(d4_fetch_req), .fetch_pc(d4_fetch_pc),
    .stall(d4_stall), .fetch_valid(d4_fetch_valid), .instruction(d4_instruction),
    .fetch_err(d4_fetch_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch-port cycle on the main instance; expectations go through the scoreboard.
  task automatic fetch_cycle(input logic req, input logic [AW-1:0] pc, input logic stl);
    exp_t e;
    fetch_req = req;
    fetch_pc  = pc;
    stall     = stl;
    if (req && !stl) begin
      if (int'(pc) < model_cnt) begin
        e.instr = model_mem[pc];
        e.err   = 1'b0;
      end else begin
        e.instr = 16'h0000;
        e.err   = 1'b1;
      end
      sb_q.push_back(e);
    end
    tick();
    if (stl) begin
      checks++;
      if (fetch_valid !== last_valid || instruction !== last_exp.instr || fetch_err !== last_exp.err) begin
        failures++;
        $display("FAIL stall_hold pc=%0d: got v=%b i=%h e=%b expected v=%b i=%h e=%b",
                 pc, fetch_valid, instruction, fetch_err, last_valid, last_exp.instr, last_exp.err);
      end
    end else begin
      checks++;
      if (fetch_valid !== req) begin
        failures++;
        $display("FAIL fetch_valid pc=%0d: got %b expected %b", pc, fetch_valid, req);
      end
      if (req) begin
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty pc=%0d", pc);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (instruction !== e.instr || fetch_err !== e.err) begin
            failures++;
            $display("FAIL fetch_data pc=%0d: got i=%h e=%b expected i=%h e=%b",
                     pc, instruction, fetch_err, e.instr, e.err);
          end
          last_exp = e;
        end
      end else begin
        last_exp.err = 1'b0;
        checks++;
        if (fetch_err !== 1'b0 || instruction !== last_exp.instr) begin
          failures++;
          $display("FAIL idle_hold: got i=%h e=%b expected i=%h e=0",
                   instruction, fetch_err, last_exp.instr);
        end
      end
      last_valid = req;
    end
    fetch_req = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (load_ready !== 1'b0 || load_busy !== 1'b0 || loaded_cnt !== 9'd0 ||
        fetch_valid !== 1'b0 || instruction !== 16'h0000 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_main: got rdy=%b busy=%b cnt=%0d v=%b i=%h e=%b expected all zero",
               load_ready, load_busy, loaded_cnt, fetch_valid, instruction, fetch_err);
    end
    checks++;
    if (d4_load_ready !== 1'b0 || d4_load_busy !== 1'b0 || d4_loaded_cnt !== 3'd0 ||
        d4_fetch_valid !== 1'b0 || d4_instruction !== 16'h0000 || d4_fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_d4: got rdy=%b busy=%b cnt=%0d v=%b i=%h e=%b expected all zero",
               d4_load_ready, d4_load_busy, d4_loaded_cnt, d4_fetch_valid, d4_instruction, d4_fetch_err);
    end
  endtask

  task automatic test_idle_fetch();
    fetch_cycle(1'b1, 8'd0, 1'b0);
    fetch_cycle(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_load();
    logic [IW-1:0] w [0:2];
    w[0] = 16'h1123; w[1] = 16'h9405; w[2] = 16'hC0F0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    last_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b1 || load_busy !== 1'b1 || loaded_cnt !== 9'd0) begin
      failures++;
      $display("FAIL load_enter: got rdy=%b busy=%b cnt=%0d expected 1 1 0", load_ready, load_busy, loaded_cnt);
    end
    load_valid = 1'b1; load_data = w[0];
    tick();
    checks++;
    if (loaded_cnt !== 9'd1) begin
      failures++;
      $display("FAIL load_word0: got cnt=%0d expected 1", loaded_cnt);
    end
    // Bubble cycle; a fetch request here must be ignored.
    load_valid = 1'b0; fetch_req = 1'b1; fetch_pc = 8'd0;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (loaded_cnt !== 9'd1 || load_ready !== 1'b1 || fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_bubble: got cnt=%0d rdy=%b v=%b expected 1 1 0", loaded_cnt, load_ready, fetch_valid);
    end
    load_valid = 1'b1; load_data = w[1];
    tick();
    checks++;
    if (loaded_cnt !== 9'd2) begin
      failures++;
      $display("FAIL load_word1: got cnt=%0d expected 2", loaded_cnt);
    end
    load_data = w[2]; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    checks++;
    if (loaded_cnt !== 9'd3 || load_ready !== 1'b0 || load_busy !== 1'b0) begin
      failures++;
      $display("FAIL load_done: got cnt=%0d rdy=%b busy=%b expected 3 0 0", loaded_cnt, load_ready, load_busy);
    end
    for (int i = 0; i < 3; i++) model_mem[i] = w[i];
    model_cnt = 3;
  endtask

  task automatic test_back_to_back();
    fetch_cycle(1'b1, 8'd0, 1'b0);
    fetch_cycle(1'b1, 8'd1, 1'b0);
    fetch_cycle(1'b1, 8'd2, 1'b0);
    fetch_cycle(1'b1, 8'd3, 1'b0);
    fetch_cycle(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_stall();
    fetch_cycle(1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) fetch_cycle(1'b1, 8'd2, 1'b1);
    fetch_cycle(1'b1, 8'd2, 1'b0);
    fetch_cycle(1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_depth4();
    logic [IW-1:0] w [0:5];
    logic [2:0]    exp_cnt;
    logic          exp_rdy;
    w[0] = 16'hA001; w[1] = 16'hA102; w[2] = 16'hA203;
    w[3] = 16'hA304; w[4] = 16'hBEEF; w[5] = 16'hDEAD;
    d4_load_start = 1'b1;
    tick();
    d4_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d4_load_valid = 1'b1; d4_load_data = w[i];
      tick();
      exp_cnt = (i < 3) ? 3'(i + 1) : 3'd4;
      exp_rdy = (i < 3);
      checks++;
      if (d4_loaded_cnt !== exp_cnt || d4_load_ready !== exp_rdy || d4_load_busy !== exp_rdy) begin
        failures++;
        $display("FAIL d4_load cyc=%0d: got cnt=%0d rdy=%b busy=%b expected %0d %b %b",
                 i, d4_loaded_cnt, d4_load_ready, d4_load_busy, exp_cnt, exp_rdy, exp_rdy);
      end
    end
    d4_load_valid = 1'b0;
    d4_fetch_req = 1'b1; d4_fetch_pc = 2'd3;
    tick();
    checks++;
    if (d4_fetch_valid !== 1'b1 || d4_instruction !== w[3] || d4_fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL d4_fetch3: got v=%b i=%h e=%b expected 1 %h 0", d4_fetch_valid, d4_instruction, d4_fetch_err, w[3]);
    end
    d4_fetch_pc = 2'd0;
    tick();
    checks++;
    if (d4_fetch_valid !== 1'b1 || d4_instruction !== w[0] || d4_fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL d4_fetch0: got v=%b i=%h e=%b expected 1 %h 0", d4_fetch_valid, d4_instruction, d4_fetch_err, w[0]);
    end
    d4_fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_reload_and_reset();
    // load_start in RUN drops the concurrent fetch.
    fetch_req = 1'b1; fetch_pc = 8'd0; load_start = 1'b1;
    tick();
    fetch_req = 1'b0; load_start = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || load_busy !== 1'b1 || loaded_cnt !== 9'd0) begin
      failures++;
      $display("FAIL run_reload: got v=%b busy=%b cnt=%0d expected 0 1 0", fetch_valid, load_busy, loaded_cnt);
    end
    load_valid = 1'b1; load_data = 16'h5555;
    tick();
    // Restart with a simultaneous word: the word is discarded.
    load_start = 1'b1; load_data = 16'h6666;
    tick();
    load_start = 1'b0;
    checks++;
    if (loaded_cnt !== 9'd0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_restart: got cnt=%0d rdy=%b expected 0 1", loaded_cnt, load_ready);
    end
    load_data = 16'h7777;
    tick();
    load_data = 16'h8888;
    tick();
    load_valid = 1'b0;
    checks++;
    if (loaded_cnt !== 9'd2) begin
      failures++;
      $display("FAIL midload_cnt: got cnt=%0d expected 2", loaded_cnt);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (loaded_cnt !== 9'd0 || load_ready !== 1'b0 || load_busy !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: got cnt=%0d rdy=%b busy=%b expected 0 0 0", loaded_cnt, load_ready, load_busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (loaded_cnt !== 9'd0 || load_ready !== 1'b0 || load_busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got cnt=%0d rdy=%b busy=%b expected 0 0 0", loaded_cnt, load_ready, load_busy);
    end
    model_cnt      = 0;
    last_valid     = 1'b0;
    last_exp.instr = 16'h0000;
    last_exp.err   = 1'b0;
    fetch_cycle(1'b1, 8'd0, 1'b0);
    fetch_cycle(1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 16'h0000;
    fetch_req = 1'b0; fetch_pc = 8'd0; stall = 1'b0;
    d4_load_start = 1'b0; d4_load_valid = 1'b0; d4_load_last = 1'b0; d4_load_data = 16'h0000;
    d4_fetch_req = 1'b0; d4_fetch_pc = 2'd0; d4_stall = 1'b0;
    model_cnt = 0; last_valid = 1'b0;
    last_exp.instr = 16'h0000; last_exp.err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_idle_fetch();
    test_load();
    test_back_to_back();
    test_stall();
    test_depth4();
    test_reload_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
